overlay_mixer: RTL and testbench

OVERLAY_MIXER -- requirements
Module: overlay_mixer

---
 rtl/overlay_mixer.sv | 172 +++++++++++++++++
 tb/tb_overlay_mixer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/overlay_mixer.sv
// Overlay mixer: keys an overlay image, streamed from a first-word-fall-through
// FIFO, over the background video inside a per-frame latched window.
//
// Ports:
//   pixelClock, reset_n          clock, async active-low reset
//   deIn, hsyncIn, vsyncIn       input timing
//   bgData                       background RGB aligned with deIn
//   fifoData, fifoEmpty          overlay FIFO head word and empty flag
//   fifoRead                     pop the overlay FIFO this cycle
//   ovlEnable, ovlX, ovlY        overlay enable and top-left, latched at frame start
//   DE, HSYNC, VSYNC, data       output video, 2 cycles behind the inputs
//   underflow                    sticky FIFO underflow, cleared at frame start
//   frameStart                   pulse in the cycle vsyncIn becomes active
module overlay_mixer #(
  parameter int unsigned width     = 1920,
  parameter int unsigned height    = 1080,
  parameter int unsigned ovlWidth  = 256,
  parameter int unsigned ovlHeight = 256,
  parameter logic [23:0] keyColour = 24'hFF00FF,
  parameter bit          hPolarity = 1'b1,
  parameter bit          vPolarity = 1'b1
) (
  input  logic        pixelClock,
  input  logic        reset_n,
  input  logic        deIn,
  input  logic        hsyncIn,
  input  logic        vsyncIn,
  input  logic [23:0] bgData,
  input  logic [23:0] fifoData,
  input  logic        fifoEmpty,
  output logic        fifoRead,
  input  logic        ovlEnable,
  input  logic [11:0] ovlX,
  input  logic [11:0] ovlY,
  output logic        DE,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic [23:0] data,
  output logic        underflow,
  output logic        frameStart
);

  localparam logic [1:0] WAIT_SYNC = 2'd0;
  localparam logic [1:0] RUN       = 2'd1;
  localparam logic [1:0] SKIP      = 2'd2;

  localparam logic [12:0] ActW = 13'(width);
  localparam logic [12:0] ActH = 13'(height);
  localparam logic [12:0] OvlW = 13'(ovlWidth);
  localparam logic [12:0] OvlH = 13'(ovlHeight);

  logic        vs_act, vs_act_q, frame_start;
  logic        de_q;
  logic [11:0] x_q, y_q;
  logic        en_q;
  logic [11:0] ox_q, oy_q;
  logic [1:0]  state_q, state_d;
  logic        in_x, in_y, in_window, uf_event;

  logic        de1_q, hs1_q, vs1_q, hit1_q;
  logic [23:0] bg1_q, ovl1_q;
  logic [23:0] data_d;

  assign vs_act      = (vsyncIn == vPolarity);
  // vs_act_q resets to "active" so a vsync already active at release is not a frame start.
  assign frame_start = vs_act & ~vs_act_q;
  assign frameStart  = frame_start;

  // 13-bit compares: the window end never wraps and the active edge clips it.
  assign in_x = ({1'b0, x_q} >= {1'b0, ox_q}) && ({1'b0, x_q} < ({1'b0, ox_q} + OvlW)) &&
                ({1'b0, x_q} < ActW);
  assign in_y = ({1'b0, y_q} >= {1'b0, oy_q}) && ({1'b0, y_q} < ({1'b0, oy_q} + OvlH)) &&
                ({1'b0, y_q} < ActH);
  assign in_window = deIn & en_q & in_x & in_y;

  assign fifoRead = (state_q == RUN) & in_window & ~fifoEmpty;
  assign uf_event = (state_q == RUN) & in_window & fifoEmpty;

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_SYNC: if (frame_start) state_d = RUN;
      RUN:       if (uf_event) state_d = SKIP;
      SKIP:      if (frame_start) state_d = RUN;
      default:   state_d = WAIT_SYNC;
    endcase
  end

  // Counters, per-frame latches and control state.
  always_ff @(posedge pixelClock or negedge reset_n) begin
    if (!reset_n) begin
      vs_act_q  <= 1'b1;
      de_q      <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      en_q      <= 1'b0;
      ox_q      <= '0;
      oy_q      <= '0;
      state_q   <= WAIT_SYNC;
      underflow <= 1'b0;
    end else begin
      vs_act_q <= vs_act;
      de_q     <= deIn;
      state_q  <= state_d;
      if (deIn) begin
        x_q <= x_q + 12'd1;
      end else if (de_q) begin
        x_q <= '0;
      end
      if (frame_start) begin
        y_q  <= '0;
        en_q <= ovlEnable;
        ox_q <= ovlX;
        oy_q <= ovlY;
      end else if (de_q && !deIn) begin
        y_q <= y_q + 12'd1;
      end
      // A same-cycle underflow wins over the frame-start clear.
      if (uf_event) begin
        underflow <= 1'b1;
      end else if (frame_start) begin
        underflow <= 1'b0;
      end
    end
  end

  // Stage 1: capture timing, background and the popped overlay word.
  always_ff @(posedge pixelClock or negedge reset_n) begin
    if (!reset_n) begin
      de1_q  <= 1'b0;
      hs1_q  <= !hPolarity;
      vs1_q  <= !vPolarity;
      hit1_q <= 1'b0;
      bg1_q  <= '0;
      ovl1_q <= '0;
    end else begin
      de1_q  <= deIn;
      hs1_q  <= hsyncIn;
      vs1_q  <= vsyncIn;
      hit1_q <= fifoRead;
      bg1_q  <= bgData;
      if (fifoRead) begin
        ovl1_q <= fifoData;
      end
    end
  end

  always_comb begin
    data_d = bg1_q;
    if (!de1_q) begin
      data_d = '0;
    end else if (hit1_q && (ovl1_q != keyColour)) begin
      data_d = ovl1_q;
    end
  end

  // Stage 2: output registers.
  always_ff @(posedge pixelClock or negedge reset_n) begin
    if (!reset_n) begin
      DE    <= 1'b0;
      HSYNC <= !hPolarity;
      VSYNC <= !vPolarity;
      data  <= '0;
    end else begin
      DE    <= de1_q;
      HSYNC <= hs1_q;
      VSYNC <= vs1_q;
      data  <= data_d;
    end
  end

endmodule

// File: tb/tb_overlay_mixer.sv
// Bench for overlay_mixer on a reduced 64x32 raster (80x36 total) with a 16x8 overlay.
// A reference model predicts fifoRead/frameStart/underflow every cycle and pushes the
// expected delayed outputs into a scoreboard queue that is popped two cycles later.
module tb_overlay_mixer;

  localparam int W  = 64;
  localparam int H  = 32;
  localparam int OW = 16;
  localparam int OH = 8;
  localparam int HT = 80;
  localparam int VT = 36;
  localparam logic [23:0] KEY = 24'hFF00FF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        deIn, hsyncIn, vsyncIn;
  logic [23:0] bgData, fifoData;
  logic        fifoEmpty, fifoRead;
  logic        ovlEnable;
  logic [11:0] ovlX, ovlY;
  logic        DE, HSYNC, VSYNC;
  logic [23:0] data;
  logic        underflow, frameStart;

  always #5 clk = ~clk;

  overlay_mixer #(
    .width    (W),
    .height   (H),
    .ovlWidth (OW),
    .ovlHeight(OH),
    .keyColour(KEY),
    .hPolarity(1'b1),
    .vPolarity(1'b1)
  ) dut (
    .pixelClock(clk),
    .reset_n   (reset_n),
    .deIn      (deIn),
    .hsyncIn   (hsyncIn),
    .vsyncIn   (vsyncIn),
    .bgData    (bgData),
    .fifoData  (fifoData),
    .fifoEmpty (fifoEmpty),
    .fifoRead  (fifoRead),
    .ovlEnable (ovlEnable),
    .ovlX      (ovlX),
    .ovlY      (ovlY),
    .DE        (DE),
    .HSYNC     (HSYNC),
    .VSYNC     (VSYNC),
    .data      (data),
    .underflow (underflow),
    .frameStart(frameStart)
  );

  typedef struct {
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] d;
    int          x;
    int          y;
  } exp_t;

  exp_t q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int hc = 0, vc = 0;
  // Reference model state.
  bit m_vsprev, m_en, m_uf;
  int m_mode;  // 0 waiting for sync, 1 running, 2 skipping
  int m_ox, m_oy;
  // FIFO model and DUT read counters.
  bit inject_key = 0;
  int rd_total = 0, reads_frame = 0, last_reads = 0;
  int fx = -1, fy = -1;
  // Output capture for one chosen pixel.
  int cap_x = -1, cap_y = -1;
  logic [23:0] cap_data;

  function automatic logic [23:0] bg_of(int x, int y);
    return {8'(y), 8'(x), 8'h3C};
  endfunction

  task automatic drive();
    deIn      = (hc < W) && (vc < H);
    hsyncIn   = (hc >= W + 4) && (hc < W + 12);
    vsyncIn   = (vc == H + 1) || (vc == H + 2);
    bgData    = bg_of(hc, vc);
    fifoEmpty = (hc == fx) && (vc == fy);
    fifoData  = inject_key ? KEY : {8'h10, 16'(rd_total)};
  endtask

  task automatic advance();
    hc++;
    if (hc == HT) begin
      hc = 0;
      vc++;
      if (vc == VT) vc = 0;
    end
  endtask

  task automatic enter_reset();
    exp_t idle;
    reset_n = 1'b0;
    m_mode = 0; m_uf = 0; m_vsprev = 1; m_en = 0; m_ox = 0; m_oy = 0;
    idle = '{de: 1'b0, hs: 1'b0, vs: 1'b0, d: 24'h0, x: -1, y: -1};
    q.delete();
    q.push_back(idle);
    q.push_back(idle);
  endtask

  task automatic leave_reset();
    reset_n = 1'b1;
    reads_frame = 0;
  endtask

  // One pixel clock: drive, check combinational outputs and the scoreboard head, update model.
  task automatic tick();
    exp_t e, n;
    logic fs, win, rd;
    logic [23:0] w;
    drive();
    @(negedge clk);
    fs  = vsyncIn && !m_vsprev;
    win = deIn && m_en && hc >= m_ox && hc < m_ox + OW && vc >= m_oy && vc < m_oy + OH;
    rd  = (m_mode == 1) && win && !fifoEmpty;
    w   = fifoData;
    n_checks++;
    if (fifoRead !== rd)
      $display("FAIL fifoRead @(%0d,%0d): got %b expected %b", hc, vc, fifoRead, rd);
    else n_pass++;
    n_checks++;
    if (frameStart !== fs)
      $display("FAIL frameStart @(%0d,%0d): got %b expected %b", hc, vc, frameStart, fs);
    else n_pass++;
    n_checks++;
    if (underflow !== m_uf)
      $display("FAIL underflow @(%0d,%0d): got %b expected %b", hc, vc, underflow, m_uf);
    else n_pass++;
    e = q.pop_front();
    n_checks++;
    if ({DE, HSYNC, VSYNC, data} !== {e.de, e.hs, e.vs, e.d})
      $display("FAIL video_out pixel(%0d,%0d): got de=%b hs=%b vs=%b d=%h expected de=%b hs=%b vs=%b d=%h",
               e.x, e.y, DE, HSYNC, VSYNC, data, e.de, e.hs, e.vs, e.d);
    else n_pass++;
    if (e.de && e.x == cap_x && e.y == cap_y) cap_data = data;
    n.de = deIn; n.hs = hsyncIn; n.vs = vsyncIn; n.x = hc; n.y = vc;
    n.d  = !deIn ? 24'h0 : (rd && w != KEY) ? w : bgData;
    q.push_back(n);
    // The FIFO pops on the DUT's own request, as a real FIFO would.
    if (fifoRead === 1'b1) begin
      rd_total++;
      reads_frame++;
      inject_key = 0;
    end
    if (m_mode == 1 && win && fifoEmpty) begin
      m_uf = 1; m_mode = 2;
    end else if (fs) begin
      m_uf = 0; m_mode = 1;
    end
    if (fs) begin
      m_en = ovlEnable; m_ox = int'(ovlX); m_oy = int'(ovlY);
      last_reads = reads_frame;
      reads_frame = 0;
    end
    m_vsprev = vsyncIn;
    @(posedge clk);
    #1;
    advance();
  endtask

  task automatic run_until(int thc, int tvc, string name);
    int budget = 2 * HT * VT;
    while (!(hc == thc && vc == tvc) && budget > 0) begin
      tick();
      budget--;
    end
    n_checks++;
    if (budget == 0)
      $display("FAIL %s: position (%0d,%0d) not reached, got (%0d,%0d)", name, thc, tvc, hc, vc);
    else n_pass++;
  endtask

  task automatic next_frame(string name);
    run_until(0, H + 1, name);
    tick();
  endtask

  task automatic test_reset();
    hc = 3; vc = 5;
    #1;
    enter_reset();
    drive();
    hsyncIn = 1'b1; vsyncIn = 1'b1;
    #2;
    n_checks++; if (DE !== 1'b0) $display("FAIL reset_DE: got %b expected 0", DE); else n_pass++;
    n_checks++; if (data !== 24'h0) $display("FAIL reset_data: got %h expected 0", data); else n_pass++;
    n_checks++; if (fifoRead !== 1'b0) $display("FAIL reset_fifoRead: got %b expected 0", fifoRead); else n_pass++;
    n_checks++; if (underflow !== 1'b0) $display("FAIL reset_underflow: got %b expected 0", underflow); else n_pass++;
    n_checks++; if (frameStart !== 1'b0) $display("FAIL reset_frameStart: got %b expected 0", frameStart); else n_pass++;
    n_checks++; if (HSYNC !== 1'b0) $display("FAIL reset_HSYNC: got %b expected 0", HSYNC); else n_pass++;
    n_checks++; if (VSYNC !== 1'b0) $display("FAIL reset_VSYNC: got %b expected 0", VSYNC); else n_pass++;
    repeat (3) begin
      @(posedge clk); #1; advance(); drive(); hsyncIn = 1'b1; vsyncIn = 1'b1;
    end
    #1;
    n_checks++; if (DE !== 1'b0) $display("FAIL reset_hold_DE: got %b expected 0", DE); else n_pass++;
    n_checks++; if (data !== 24'h0) $display("FAIL reset_hold_data: got %h expected 0", data); else n_pass++;
    n_checks++; if (HSYNC !== 1'b0) $display("FAIL reset_hold_HSYNC: got %b expected 0", HSYNC); else n_pass++;
    @(posedge clk); #1; advance();
    leave_reset();
  endtask

  task automatic test_wait_sync();
    next_frame("wait_sync");
    n_checks++;
    if (last_reads != 0) $display("FAIL wait_sync_reads: got %0d expected 0", last_reads);
    else n_pass++;
  endtask

  task automatic test_basic_overlay();
    next_frame("basic");
    n_checks++;
    if (last_reads != OW * OH) $display("FAIL basic_reads: got %0d expected %0d", last_reads, OW * OH);
    else n_pass++;
  endtask

  task automatic test_colour_key();
    inject_key = 1; cap_x = 10; cap_y = 5; cap_data = 'x;
    next_frame("key");
    n_checks++;
    if (cap_data !== bg_of(10, 5)) $display("FAIL key_pixel: got %h expected %h", cap_data, bg_of(10, 5));
    else n_pass++;
    n_checks++;
    if (last_reads != OW * OH) $display("FAIL key_reads: got %0d expected %0d", last_reads, OW * OH);
    else n_pass++;
  endtask

  task automatic test_clip();
    ovlX = 12'd56; ovlY = 12'd28;
    next_frame("clip_latch");
    next_frame("clip");
    n_checks++;
    if (last_reads != (W - 56) * (H - 28))
      $display("FAIL clip_reads: got %0d expected %0d", last_reads, (W - 56) * (H - 28));
    else n_pass++;
  endtask

  task automatic test_underflow();
    ovlX = 12'd10; ovlY = 12'd5;
    next_frame("uf_latch");
    fx = 15; fy = 7;
    run_until(0, H, "uf_frame");
    fx = -1; fy = -1;
    n_checks++;
    if (underflow !== 1'b1) $display("FAIL uf_flag: got %b expected 1", underflow); else n_pass++;
    n_checks++;
    if (reads_frame != 2 * OW + 5) $display("FAIL uf_reads: got %0d expected %0d", reads_frame, 2 * OW + 5);
    else n_pass++;
    next_frame("uf_end");
    next_frame("uf_recover");
    n_checks++;
    if (last_reads != OW * OH) $display("FAIL uf_recover_reads: got %0d expected %0d", last_reads, OW * OH);
    else n_pass++;
    n_checks++;
    if (underflow !== 1'b0) $display("FAIL uf_cleared: got %b expected 0", underflow); else n_pass++;
  endtask

  task automatic test_mid_frame_reset();
    run_until(20, 8, "mid_reset_pos");
    enter_reset();
    drive();
    #1;
    n_checks++; if (DE !== 1'b0) $display("FAIL midrst_DE: got %b expected 0", DE); else n_pass++;
    n_checks++; if (data !== 24'h0) $display("FAIL midrst_data: got %h expected 0", data); else n_pass++;
    n_checks++; if (fifoRead !== 1'b0) $display("FAIL midrst_fifoRead: got %b expected 0", fifoRead); else n_pass++;
    repeat (3) begin
      @(posedge clk); #1; advance(); drive();
    end
    leave_reset();
    next_frame("midrst_resync");
    n_checks++;
    if (last_reads != 0) $display("FAIL midrst_no_reads: got %0d expected 0", last_reads); else n_pass++;
    next_frame("midrst_after");
    n_checks++;
    if (last_reads != OW * OH) $display("FAIL midrst_reads: got %0d expected %0d", last_reads, OW * OH);
    else n_pass++;
  endtask

  task automatic test_ovl_move();
    int base;
    cap_x = 30; cap_y = 5; cap_data = 'x;
    run_until(0, 2, "move_pos");
    ovlX = 12'd30;
    next_frame("move_old");
    n_checks++;
    if (cap_data !== bg_of(30, 5)) $display("FAIL move_same_frame: got %h expected %h", cap_data, bg_of(30, 5));
    else n_pass++;
    base = rd_total;
    cap_data = 'x;
    next_frame("move_new");
    n_checks++;
    if (cap_data !== {8'h10, 16'(base)})
      $display("FAIL move_next_frame: got %h expected %h", cap_data, {8'h10, 16'(base)});
    else n_pass++;
  endtask

  initial begin
    reset_n = 1'b1;
    ovlEnable = 1'b1; ovlX = 12'd10; ovlY = 12'd5;
    deIn = 0; hsyncIn = 0; vsyncIn = 0; bgData = 0; fifoData = 0; fifoEmpty = 0;
    test_reset();
    test_wait_sync();
    test_basic_overlay();
    test_colour_key();
    test_clip();
    test_underflow();
    test_mid_frame_reset();
    test_ovl_move();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
